// File: rtl/ysyx_25040111_axil_mem_slave.sv
// AXI4-Lite-style single-beat memory target with independent read/write FSMs,
// fixed access latency, byte-lane strobes and DECERR for out-of-range addresses.
module ysyx_25040111_axil_mem_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  rd_state_e   rd_state_q, rd_state_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rd_sample;
  logic [31:0] rd_src;
  logic [29:0] rd_woff;
  logic        rd_hit;

  wr_state_e   wr_state_q, wr_state_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [3:0]  wr_strb_q, wr_strb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs, commit;
  logic [31:0] wr_addr_cur, wr_data_cur;
  logic [3:0]  wr_strb_cur;
  logic [29:0] wr_woff;
  logic        wr_hit;

  // With zero latency the sample/commit happens on the accepting edge, so decode the live inputs.
  assign rd_src  = (rd_state_q == R_IDLE) ? araddr : rd_addr_q;
  assign rd_woff = 30'((rd_src - ADDR_BASE) >> 2);
  assign rd_hit  = ~|rd_woff[29:IDX_W];

  assign wr_addr_cur = aw_got_q ? wr_addr_q : awaddr;
  assign wr_data_cur = w_got_q ? wr_data_q : wdata;
  assign wr_strb_cur = w_got_q ? wr_strb_q : wstrb;
  assign wr_woff     = 30'((wr_addr_cur - ADDR_BASE) >> 2);
  assign wr_hit      = ~|wr_woff[29:IDX_W];

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_addr_d  = rd_addr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_sample  = 1'b0;
    case (rd_state_q)
      R_IDLE: if (arvalid) begin
        rd_addr_d = araddr;
        rd_cnt_d  = 4'(RD_LAT);
        if (RD_LAT == 0) begin
          rd_sample  = 1'b1;
          rd_state_d = R_RESP;
        end else begin
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rd_cnt_d = rd_cnt_q - 4'd1;
        if (rd_cnt_q == 4'd1) begin
          rd_sample  = 1'b1;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: if (rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
    if (rd_sample) begin
      rdata_d = rd_hit ? mem_q[rd_woff[IDX_W-1:0]] : 32'h0;
      rresp_d = rd_hit ? 2'b00 : 2'b11;
    end
  end

  assign aw_hs = (wr_state_q == W_IDLE) && !aw_got_q && awvalid;
  assign w_hs  = (wr_state_q == W_IDLE) && !w_got_q && wvalid;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d  = 1'b1;
          wr_addr_d = awaddr;
        end
        if (w_hs) begin
          w_got_d   = 1'b1;
          wr_data_d = wdata;
          wr_strb_d = wstrb;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          wr_cnt_d = 4'(WR_LAT);
          if (WR_LAT == 0) begin
            commit     = 1'b1;
            wr_state_d = W_RESP;
          end else begin
            wr_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        wr_cnt_d = wr_cnt_q - 4'd1;
        if (wr_cnt_q == 4'd1) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: if (bready) begin
        aw_got_d   = 1'b0;
        w_got_d    = 1'b0;
        wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (commit) bresp_d = wr_hit ? 2'b00 : 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      bresp_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      bresp_q    <= bresp_d;
    end
  end

  // Memory is not reset; a same-edge read sees the pre-write word because both use NBA.
  always_ff @(posedge clk) begin
    if (commit && wr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_cur[i]) mem_q[wr_woff[IDX_W-1:0]][8*i +: 8] <= wr_data_cur[8*i +: 8];
      end
    end
  end

  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = (wr_state_q == W_IDLE) && !aw_got_q;
  assign wready  = (wr_state_q == W_IDLE) && !w_got_q;
  assign bvalid  = (wr_state_q == W_RESP);
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_25040111_axil_mem_slave.sv
// Self-checking bench: directed scenarios plus randomized traffic against a word-array model.
module tb_ysyx_25040111_axil_mem_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          RDL   = 2;
  localparam int          WRL   = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  ysyx_25040111_axil_mem_slave #(
    .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(RDL), .WR_LAT(WRL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [DEPTH];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic bit ref_hit(input logic [31:0] a);
    longint unsigned la, lo, hi;
    la = 64'(a);
    lo = 64'(BASE);
    hi = lo + 64'(4 * DEPTH);
    return (la >= lo) && (la < hi);
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((64'(a) - 64'(BASE)) / 4);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (ref_hit(a))
      for (int i = 0; i < 4; i++)
        if (s[i]) model[ref_idx(a)][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic do_read(input logic [31:0] a, input int bp, input bit pre,
                         output logic [31:0] d, output logic [1:0] r, output int lat, output bit ok);
    int n;
    ok = 1;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = pre;
    n = 0;
    while (arready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) begin ok = 0; break; end
    end
    @(negedge clk);
    arvalid = 1'b0; araddr = $urandom; lat = 1;
    while (rvalid !== 1'b1 && lat < 60) begin
      if (arready !== 1'b0) ok = 0;
      @(negedge clk);
      lat++;
    end
    if (lat >= 60) ok = 0;
    d = rdata; r = rresp;
    if (!pre) begin
      for (int i = 0; i < bp; i++) begin
        if (rvalid !== 1'b1 || rdata !== d || rresp !== r || arready !== 1'b0) ok = 0;
        @(negedge clk);
      end
      rready = 1'b1;
    end
    if (rvalid !== 1'b1 || rdata !== d || rresp !== r) ok = 0;
    @(negedge clk);
    rready = 1'b0;
    if (rvalid !== 1'b0 || arready !== 1'b1) ok = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] dd, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int bp, input bit pre,
                          output logic [1:0] resp, output int lat, output bit ok);
    bit aw_done, w_done;
    int c;
    ok = 1; aw_done = 0; w_done = 0; c = 0;
    bready = pre;
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (aw_done && awready !== 1'b0) ok = 0;
      if (w_done && wready !== 1'b0) ok = 0;
      awvalid = !aw_done && (c >= aw_dly);
      awaddr  = awvalid ? a : $urandom;
      wvalid  = !w_done && (c >= w_dly);
      wdata   = wvalid ? dd : $urandom;
      wstrb   = wvalid ? s : 4'($urandom);
      if (awvalid && awready === 1'b1) aw_done = 1;
      if (wvalid && wready === 1'b1) w_done = 1;
      c++;
      if (c > 100) begin ok = 0; break; end
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; lat = 1;
    while (bvalid !== 1'b1 && lat < 60) begin
      if (awready !== 1'b0 || wready !== 1'b0) ok = 0;
      @(negedge clk);
      lat++;
    end
    if (lat >= 60) ok = 0;
    resp = bresp;
    if (!pre) begin
      for (int i = 0; i < bp; i++) begin
        if (bvalid !== 1'b1 || bresp !== resp || awready !== 1'b0 || wready !== 1'b0) ok = 0;
        @(negedge clk);
      end
      bready = 1'b1;
    end
    if (bvalid !== 1'b1 || bresp !== resp) ok = 0;
    @(negedge clk);
    bready = 1'b0;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) ok = 0;
  endtask

  task automatic test_reset();
    logic [38:0] got, exp;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp};
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required %h", got, exp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [1:0] resp; int lat; bit ok; logic [31:0] d; int idx;
    for (int k = 0; k < 17; k++) begin
      idx = (k == 16) ? DEPTH - 1 : k;
      d = $urandom;
      do_write(BASE + 32'(4 * idx), d, 4'hF, 0, 0, 0, 1'b1, resp, lat, ok);
      ref_write(BASE + 32'(4 * idx), d, 4'hF);
      n_cmp++;
      if (resp !== 2'b00 || !ok || lat !== 1 + WRL) begin
        n_bad++;
        $display("FAIL init_write[%0d]: got resp=%b ok=%0d lat=%0d required resp=00 ok=1 lat=%0d",
                 idx, resp, ok, lat, 1 + WRL);
      end
    end
  endtask

  task automatic test_basic_rw();
    logic [1:0] resp, r; int lat; bit ok; logic [31:0] d;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0, resp, lat, ok);
    ref_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    n_cmp++;
    if (resp !== 2'b00 || !ok) begin
      n_bad++; $display("FAIL basic_write: got resp=%b ok=%0d required resp=00 ok=1", resp, ok);
    end
    do_read(32'h8000_0010, 0, 1'b0, d, r, lat, ok);
    n_cmp++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
      n_bad++; $display("FAIL basic_read: got %h/%b required deadbeef/00", d, r);
    end
    n_cmp++;
    if (lat !== 1 + RDL || !ok) begin
      n_bad++; $display("FAIL basic_read_lat: got lat=%0d ok=%0d required lat=%0d ok=1", lat, ok, 1 + RDL);
    end
  endtask

  task automatic test_byte_lanes();
    logic [1:0] resp, r; int lat; bit ok; logic [31:0] d;
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, 0, 1'b1, resp, lat, ok);
    ref_write(32'h8000_0020, 32'h1122_3344, 4'hF);
    do_write(32'h8000_0021, 32'h0000_AA00, 4'b0010, 0, 0, 0, 1'b1, resp, lat, ok);
    ref_write(32'h8000_0021, 32'h0000_AA00, 4'b0010);
    do_read(32'h8000_0020, 0, 1'b1, d, r, lat, ok);
    n_cmp++;
    if (d !== 32'h1122_AA44 || r !== 2'b00) begin
      n_bad++; $display("FAIL byte_lanes: got %h/%b required 1122aa44/00", d, r);
    end
    do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, 1'b1, resp, lat, ok);
    do_read(32'h8000_0020, 0, 1'b1, d, r, lat, ok);
    n_cmp++;
    if (d !== 32'h1122_AA44 || resp !== 2'b00) begin
      n_bad++; $display("FAIL zero_strobe: got %h/bresp=%b required 1122aa44/00", d, resp);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp, r; int lat; bit ok; logic [31:0] d;
    do_write(32'h8000_0008, 32'hCAFE_F00D, 4'hF, 3, 0, 0, 1'b0, resp, lat, ok);
    ref_write(32'h8000_0008, 32'hCAFE_F00D, 4'hF);
    n_cmp++;
    if (lat !== 1 + WRL || !ok || resp !== 2'b00) begin
      n_bad++; $display("FAIL w_before_aw: got lat=%0d ok=%0d resp=%b required lat=%0d ok=1 resp=00",
                        lat, ok, resp, 1 + WRL);
    end
    do_write(32'h8000_000C, 32'h0BAD_CAFE, 4'hF, 0, 4, 0, 1'b0, resp, lat, ok);
    ref_write(32'h8000_000C, 32'h0BAD_CAFE, 4'hF);
    n_cmp++;
    if (lat !== 1 + WRL || !ok) begin
      n_bad++; $display("FAIL aw_before_w: got lat=%0d ok=%0d required lat=%0d ok=1", lat, ok, 1 + WRL);
    end
    do_read(32'h8000_0008, 0, 1'b0, d, r, lat, ok);
    n_cmp++;
    if (d !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL w_before_aw_data: got %h required cafef00d", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp, r; int lat; bit ok; logic [31:0] d;
    do_read(32'h7FFF_FFFC, 0, 1'b0, d, r, lat, ok);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b11 || !ok) begin
      n_bad++; $display("FAIL oor_read_low: got %h/%b ok=%0d required 00000000/11 ok=1", d, r, ok);
    end
    do_read(32'h8000_0FFC, 0, 1'b0, d, r, lat, ok);
    n_cmp++;
    if (d !== model[DEPTH-1] || r !== 2'b00) begin
      n_bad++; $display("FAIL last_word_read: got %h/%b required %h/00", d, r, model[DEPTH-1]);
    end
    do_write(32'h8000_1000, 32'h5555_5555, 4'hF, 0, 0, 0, 1'b0, resp, lat, ok);
    n_cmp++;
    if (resp !== 2'b11 || !ok) begin
      n_bad++; $display("FAIL oor_write_resp: got %b ok=%0d required 11 ok=1", resp, ok);
    end
    do_read(BASE, 0, 1'b0, d, r, lat, ok);
    n_cmp++;
    if (d !== model[0] || r !== 2'b00) begin
      n_bad++; $display("FAIL oor_write_word0: got %h/%b required %h/00", d, r, model[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp, r; int lat; bit ok; logic [31:0] d;
    do_read(32'h8000_0004, 5, 1'b0, d, r, lat, ok);
    n_cmp++;
    if (!ok || d !== model[1]) begin
      n_bad++; $display("FAIL r_backpressure: got ok=%0d data=%h required ok=1 data=%h", ok, d, model[1]);
    end
    do_write(32'h8000_0004, 32'h1234_5678, 4'b1001, 0, 0, 5, 1'b0, resp, lat, ok);
    ref_write(32'h8000_0004, 32'h1234_5678, 4'b1001);
    n_cmp++;
    if (!ok || resp !== 2'b00) begin
      n_bad++; $display("FAIL b_backpressure: got ok=%0d resp=%b required ok=1 resp=00", ok, resp);
    end
  endtask

  task automatic test_collision();
    logic [1:0] resp, r; int wlat, rlat; bit wok, rok; logic [31:0] d, old_v, new_v;
    old_v = model[5];
    new_v = ~old_v;
    fork
      do_write(32'h8000_0014, new_v, 4'hF, 0, 0, 0, 1'b1, resp, wlat, wok);
      do_read(32'h8000_0014, 0, 1'b1, d, r, rlat, rok);
    join
    ref_write(32'h8000_0014, new_v, 4'hF);
    n_cmp++;
    if (d !== old_v || !rok || !wok) begin
      n_bad++; $display("FAIL collision_old: got %h ok=%0d/%0d required %h ok=1/1", d, rok, wok, old_v);
    end
    do_read(32'h8000_0014, 0, 1'b1, d, r, rlat, rok);
    n_cmp++;
    if (d !== new_v) begin
      n_bad++; $display("FAIL collision_new: got %h required %h", d, new_v);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] r; int lat; bit ok; logic [31:0] d;
    logic [4:0] got;
    @(negedge clk);
    awaddr = 32'h8000_0018; awvalid = 1'b1;
    wdata = ~model[6]; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    got = {bvalid, awready, wready, arready, rvalid};
    n_cmp++;
    if (got !== 5'b01110) begin
      n_bad++; $display("FAIL reset_mid_write: got %b required 01110", got);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_read(32'h8000_0018, 0, 1'b0, d, r, lat, ok);
    n_cmp++;
    if (d !== model[6] || r !== 2'b00) begin
      n_bad++; $display("FAIL reset_mem_unchanged: got %h/%b required %h/00", d, r, model[6]);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, r; int lat; bit ok; logic [31:0] a, d, dd; logic [3:0] s;
    int idx, sel;
    for (int it = 0; it < 60; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8) begin
        idx = int'($urandom_range(0, 16));
        if (idx == 16) idx = DEPTH - 1;
        a = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
      end else if (sel == 8) begin
        a = BASE - 32'(4 * $urandom_range(1, 8));
      end else begin
        a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
      end
      if ($urandom_range(0, 1) == 0) begin
        dd = $urandom; s = 4'($urandom);
        do_write(a, dd, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom), resp, lat, ok);
        ref_write(a, dd, s);
        n_cmp++;
        if (resp !== (ref_hit(a) ? 2'b00 : 2'b11) || lat !== 1 + WRL || !ok) begin
          n_bad++; $display("FAIL rand_write[%0d] a=%h: got resp=%b lat=%0d ok=%0d required resp=%b lat=%0d ok=1",
                            it, a, resp, lat, ok, ref_hit(a) ? 2'b00 : 2'b11, 1 + WRL);
        end
      end else begin
        do_read(a, int'($urandom_range(0, 3)), 1'($urandom), d, r, lat, ok);
        n_cmp++;
        if (d !== (ref_hit(a) ? model[ref_idx(a)] : 32'h0) || r !== (ref_hit(a) ? 2'b00 : 2'b11)
            || lat !== 1 + RDL || !ok) begin
          n_bad++; $display("FAIL rand_read[%0d] a=%h: got %h/%b lat=%0d ok=%0d required %h/%b lat=%0d ok=1",
                            it, a, d, r, lat, ok, ref_hit(a) ? model[ref_idx(a)] : 32'h0,
                            ref_hit(a) ? 2'b00 : 2'b11, 1 + RDL);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic_rw();
    test_byte_lanes();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_25040111_axil_mem_slave.md
# ysyx_25040111_axil_mem_slave

AXI4-Lite-style single-beat memory responder: the target end of the load/store unit's AR/R and AW/W/B channels. It accepts one read and one write transaction at a time, models a fixed access latency, and holds a word-addressed internal memory with byte-lane write strobes. Out-of-range addresses get an error response. It replaces behavioural memory in non-SoC simulation and serves as the reference target for the LSU handshake.

## Interface
Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0
- DEPTH_WORDS, 1024, number of 32-bit words (power of two)
- RD_LAT, 2, wait cycles between AR acceptance and rvalid (0..15)
- WR_LAT, 2, wait cycles between AW+W acceptance and write commit (0..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- araddr  in  32  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data, full aligned word
- rresp  out  2  read response: 00 OKAY, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data, lane-aligned by the initiator
- wstrb  in  4  byte-lane enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response: 00 OKAY, 11 DECERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready

## Operation
- Decode: in range iff ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS. Word index = (addr - ADDR_BASE) >> 2, truncated to log2(DEPTH_WORDS) bits. addr[1:0] is ignored.
- Read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE:
  - R_IDLE: arready=1. On arvalid, latch araddr and load counter with RD_LAT. Go to R_WAIT, or straight to R_RESP when RD_LAT=0.
  - R_WAIT: decrement the counter. On the edge where it reaches 0, sample memory into rdata and set rresp, then go to R_RESP.
  - R_RESP: rvalid=1. rdata and rresp stay stable until rready. On rvalid&rready go to R_IDLE.
  - Out-of-range read: rdata=0, rresp=11.
- Write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. The two captures are independent and may occur in either order or in the same cycle.
  - When both are held, load the counter with WR_LAT and go to W_WAIT.
  - W_WAIT: on the edge where the counter expires, write memory lanes where wstrb[i]=1 (byte i = wdata[8i+7:8i]) and set bresp.
  - Out-of-range write: memory unchanged, bresp=11. wstrb=0000 is legal: OKAY with no change.
  - W_RESP: bvalid=1 until bready, then go to W_IDLE with awready=wready=1.
- The read and write FSMs run concurrently and independently.
- Collision: if the read sample edge equals the write commit edge at the same word, rdata returns the pre-write value. Any later read returns the new value.

## Timing
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00. FSMs go to IDLE and counters to 0. Memory contents are not reset.
- Read latency: AR handshake in cycle T -> rvalid high from cycle T+1+RD_LAT. Minimum with RD_LAT=0: rvalid one cycle after handshake.
- Write latency: the later of the AW/W handshakes in cycle T -> memory updated at the end of cycle T+WR_LAT -> bvalid high from cycle T+1+WR_LAT.
- After the rready/bready handshake in cycle T, rvalid/bvalid drop in T+1 and arready (or awready/wready) rise in T+1. Back-to-back throughput is one transaction per 2+LAT cycles per channel.
- arready stays 0 from R_WAIT through R_RESP. The AW/W ready for a captured channel stays 0 until W_IDLE is re-entered.
- rready or bready held high before valid: the handshake completes in the first valid cycle.
- rvalid/bvalid never drop without a handshake. Response outputs never change while valid is high and ready is low.
- rst_n asserted mid-transaction: the transaction is abandoned and outputs go to reset values immediately. A write whose commit edge has not occurred leaves memory unchanged.

## Test plan
- RD_LAT=2: write 32'hDEADBEEF at 0x8000_0010 (wstrb 1111), then read it. AR handshake at cycle 10 -> rvalid at cycle 13, rdata=DEADBEEF, rresp=00.
- Byte lanes: word holds 0x11223344. Write wdata=0x0000AA00 with wstrb 0010. Read back -> 0x1122AA44.
- W before AW: wvalid at cycle 5, awvalid at cycle 8. wready low from cycle 6. WR_LAT=2 -> bvalid at cycle 11, data committed.
- Out of range: read 0x7FFF_FFFC -> rdata=0, rresp=11. Write 0x8000_1000 (DEPTH 1024) -> bresp=11, word 0 unchanged.
- Backpressure: rready held 0 for 5 cycles after rvalid -> rvalid/rdata/rresp stable, arready stays 0. Repeat for B with bready held 0 -> bvalid/bresp stable.
- Collision and reset: read and write to the same word aligned so sample edge = commit edge -> read returns old value. Then assert rst_n during W_WAIT -> bvalid=0, awready=1, memory unchanged.
